// File: rtl/tft_spi_pkg.sv
// Shared definitions for the TFT SPI receive path.
// Covers the command opcodes, the decoder state type and the window-end helpers.
package tft_spi_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE,
        CASET,
        PASET,
        RAMWR_HI,
        RAMWR_LO
    } rx_state_t;

    // An inverted window (start > end) collapses to a single column/row at start
    function automatic logic [8:0] col_end(input logic [15:0] s, input logic [15:0] e);
        return (s > e) ? s[8:0] : e[8:0];
    endfunction

    function automatic logic [7:0] row_end(input logic [15:0] s, input logic [15:0] e);
        return (s > e) ? s[7:0] : e[7:0];
    endfunction

endpackage

// File: rtl/tft_spi_receiver_byte_shifter.sv
// Link synchronizers, sck rising-edge detect and MSB-first byte assembly.
// Also exports the synchronized tft_reset as an active-high clear.
module spi_byte_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tft_sck,
    input  logic       tft_sdi,
    input  logic       tft_dc,
    input  logic       tft_cs,
    input  logic       tft_reset,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       link_clear
);

    // Bit order in each stage: {reset, cs, dc, sdi, sck}; idle levels keep cs and reset inactive
    localparam logic [4:0] SYNC_IDLE = 5'b11000;

    logic [4:0] link_raw;
    logic [4:0] sync_reg [SYNC_STAGES];
    logic [4:0] sync_last;

    logic       sck_s, sdi_s, dc_s, cs_s, reset_s;
    logic       sck_prev_reg;
    logic       rise_reg;
    logic       sdi_reg;
    logic       dc_reg;
    logic [2:0] bit_cnt_reg;
    logic [6:0] shift_reg;
    logic       byte_valid_reg;
    logic [7:0] byte_data_reg;
    logic       byte_is_data_reg;

    assign link_raw  = {tft_reset, tft_cs, tft_dc, tft_sdi, tft_sck};
    assign sync_last = sync_reg[SYNC_STAGES-1];
    assign sck_s     = sync_last[0];
    assign sdi_s     = sync_last[1];
    assign dc_s      = sync_last[2];
    assign cs_s      = sync_last[3];
    assign reset_s   = sync_last[4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= SYNC_IDLE;
            end
        end else begin
            sync_reg[0] <= link_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    // Edge is registered together with sdi/dc so all three stay aligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_prev_reg <= 1'b0;
            rise_reg     <= 1'b0;
            sdi_reg      <= 1'b0;
            dc_reg       <= 1'b0;
        end else begin
            sck_prev_reg <= sck_s;
            rise_reg     <= sck_s & ~sck_prev_reg & ~cs_s;
            sdi_reg      <= sdi_s;
            dc_reg       <= dc_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_reg      <= 3'd0;
            shift_reg        <= 7'd0;
            byte_valid_reg   <= 1'b0;
            byte_data_reg    <= 8'd0;
            byte_is_data_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (!reset_s || cs_s) begin
                bit_cnt_reg <= 3'd0;
                shift_reg   <= 7'd0;
            end else if (rise_reg) begin
                shift_reg   <= {shift_reg[5:0], sdi_reg};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    byte_valid_reg   <= 1'b1;
                    byte_data_reg    <= {shift_reg, sdi_reg};
                    byte_is_data_reg <= dc_reg;
                end
            end
        end
    end

    assign byte_valid   = byte_valid_reg;
    assign byte_data    = byte_data_reg;
    assign byte_is_data = byte_is_data_reg;
    assign link_clear   = ~reset_s;

endmodule

// File: rtl/tft_spi_receiver.sv
// TFT SPI receive decoder: CASET/PASET window tracking and RAMWR pixel
// extraction with a raster cursor, fed by the byte shifter.
module tft_spi_receiver
    import tft_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int X_MAX       = 319,
    parameter int Y_MAX       = 239
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tft_sck,
    input  logic        tft_sdi,
    input  logic        tft_dc,
    input  logic        tft_cs,
    input  logic        tft_reset,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_is_data,
    output logic        pixel_valid,
    output logic [8:0]  pixel_x,
    output logic [7:0]  pixel_y,
    output logic [15:0] pixel_rgb,
    output logic        frame_done
);

    localparam logic [15:0] XE_DEFAULT = 16'(X_MAX);
    localparam logic [15:0] YE_DEFAULT = 16'(Y_MAX);

    logic       link_clear;
    logic       is_cmd;
    logic       is_data;
    logic       ramwr_start;

    rx_state_t  state_reg, state_next;
    logic [1:0] param_reg, param_next;

    logic [15:0] xs_reg, xe_reg, ys_reg, ye_reg;
    logic [8:0]  xe_eff;
    logic [7:0]  ye_eff;
    logic [8:0]  x_reg;
    logic [7:0]  y_reg;
    logic [7:0]  hi_reg;
    logic        pixel_valid_reg;
    logic        frame_done_reg;
    logic [15:0] pixel_rgb_reg;

    spi_byte_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk          (clk),
        .rst          (rst),
        .tft_sck      (tft_sck),
        .tft_sdi      (tft_sdi),
        .tft_dc       (tft_dc),
        .tft_cs       (tft_cs),
        .tft_reset    (tft_reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .link_clear   (link_clear)
    );

    assign is_cmd      = byte_valid & ~byte_is_data;
    assign is_data     = byte_valid & byte_is_data;
    assign ramwr_start = is_cmd && (byte_data == CMD_RAMWR);
    assign xe_eff      = col_end(xs_reg, xe_reg);
    assign ye_eff      = row_end(ys_reg, ye_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            param_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            param_reg <= param_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        param_next = param_reg;
        if (link_clear) begin
            state_next = IDLE;
            param_next = 2'd0;
        end else if (is_cmd) begin
            param_next = 2'd0;
            case (byte_data)
                CMD_CASET: state_next = CASET;
                CMD_PASET: state_next = PASET;
                CMD_RAMWR: state_next = RAMWR_HI;
                default:   state_next = IDLE;
            endcase
        end else if (is_data) begin
            case (state_reg)
                CASET, PASET: begin
                    param_next = param_reg + 2'd1;
                    if (param_reg == 2'd3) begin
                        state_next = IDLE;
                    end
                end
                RAMWR_HI: state_next = RAMWR_LO;
                RAMWR_LO: state_next = RAMWR_HI;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xs_reg <= 16'd0;
            xe_reg <= XE_DEFAULT;
            ys_reg <= 16'd0;
            ye_reg <= YE_DEFAULT;
        end else if (link_clear) begin
            xs_reg <= 16'd0;
            xe_reg <= XE_DEFAULT;
            ys_reg <= 16'd0;
            ye_reg <= YE_DEFAULT;
        end else if (is_data && state_reg == CASET) begin
            case (param_reg)
                2'd0:    xs_reg[15:8] <= byte_data;
                2'd1:    xs_reg[7:0]  <= byte_data;
                2'd2:    xe_reg[15:8] <= byte_data;
                default: xe_reg[7:0]  <= byte_data;
            endcase
        end else if (is_data && state_reg == PASET) begin
            case (param_reg)
                2'd0:    ys_reg[15:8] <= byte_data;
                2'd1:    ys_reg[7:0]  <= byte_data;
                2'd2:    ye_reg[15:8] <= byte_data;
                default: ye_reg[7:0]  <= byte_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg          <= 8'd0;
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            pixel_rgb_reg   <= 16'd0;
        end else begin
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            if (!link_clear && is_data && state_reg == RAMWR_HI) begin
                hi_reg <= byte_data;
            end
            if (!link_clear && is_data && state_reg == RAMWR_LO) begin
                pixel_valid_reg <= 1'b1;
                pixel_rgb_reg   <= {hi_reg, byte_data};
                frame_done_reg  <= (x_reg == xe_eff) && (y_reg == ye_eff);
            end
        end
    end

    // Cursor holds the current pixel's coordinate during pixel_valid, then steps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg <= 9'd0;
            y_reg <= 8'd0;
        end else if (!link_clear && ramwr_start) begin
            x_reg <= xs_reg[8:0];
            y_reg <= ys_reg[7:0];
        end else if (pixel_valid_reg) begin
            if (x_reg != xe_eff) begin
                x_reg <= x_reg + 9'd1;
            end else begin
                x_reg <= xs_reg[8:0];
                if (y_reg != ye_eff) begin
                    y_reg <= y_reg + 8'd1;
                end else begin
                    y_reg <= ys_reg[7:0];
                end
            end
        end
    end

    assign pixel_valid = pixel_valid_reg;
    assign pixel_x     = x_reg;
    assign pixel_y     = y_reg;
    assign pixel_rgb   = pixel_rgb_reg;
    assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_tft_spi_receiver.sv
// Directed bench for tft_spi_receiver: drives the SPI link bit by bit and
// checks bytes, pixels, coordinates and frame_done against hand-computed values.
module tb_tft_spi_receiver;

    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tft_sck = 1'b0;
    logic        tft_sdi = 1'b0;
    logic        tft_dc = 1'b0;
    logic        tft_cs = 1'b1;
    logic        tft_reset = 1'b1;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_is_data;
    logic        pixel_valid;
    logic [8:0]  pixel_x;
    logic [7:0]  pixel_y;
    logic [15:0] pixel_rgb;
    logic        frame_done;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [15:0] rgb;
        logic        fd;
    } pix_t;

    pix_t       pix_q[$];
    logic [7:0] byte_q[$];

    tft_spi_receiver #(
        .SYNC_STAGES (SS),
        .X_MAX       (319),
        .Y_MAX       (239)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tft_sck      (tft_sck),
        .tft_sdi      (tft_sdi),
        .tft_dc       (tft_dc),
        .tft_cs       (tft_cs),
        .tft_reset    (tft_reset),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_is_data (byte_is_data),
        .pixel_valid  (pixel_valid),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_rgb    (pixel_rgb),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (byte_valid) byte_q.push_back(byte_data);
        if (pixel_valid) pix_q.push_back('{pixel_x, pixel_y, pixel_rgb, frame_done});
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input logic dc);
        tft_cs = 1'b0;
        tft_dc = dc;
        for (int i = 7; i >= 0; i--) begin
            tft_sck = 1'b0;
            tft_sdi = b[i];
            repeat (3) @(negedge clk);
            tft_sck = 1'b1;
            repeat (3) @(negedge clk);
        end
        tft_sck = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_data(w[15:8]);
        send_data(w[7:0]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++; if (byte_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_byte_valid got %b expected 0", byte_valid); end
        tests_run++; if (byte_data !== 8'h00) begin tests_failed++; $display("FAIL reset_byte_data got %h expected 00", byte_data); end
        tests_run++; if (byte_is_data !== 1'b0) begin tests_failed++; $display("FAIL reset_byte_is_data got %b expected 0", byte_is_data); end
        tests_run++; if (pixel_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pixel_valid got %b expected 0", pixel_valid); end
        tests_run++; if (pixel_x !== 9'd0 || pixel_y !== 8'd0) begin tests_failed++; $display("FAIL reset_cursor got (%0d,%0d) expected (0,0)", pixel_x, pixel_y); end
        tests_run++; if (pixel_rgb !== 16'h0000) begin tests_failed++; $display("FAIL reset_pixel_rgb got %h expected 0000", pixel_rgb); end
        tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got %b expected 0", frame_done); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_byte_assembly();
        logic [7:0] b;
        int lat;
        b = 8'hA5;
        lat = -1;
        byte_q.delete();
        tft_cs = 1'b0;
        tft_dc = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tft_sck = 1'b0;
            tft_sdi = b[i];
            repeat (3) @(negedge clk);
            tft_sck = 1'b1;
            if (i == 0) begin
                for (int n = 1; n <= 10; n++) begin
                    @(posedge clk);
                    #1;
                    if (byte_valid) begin
                        lat = n - 1;
                        break;
                    end
                end
                @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
        end
        tft_sck = 1'b0;
        repeat (8) @(negedge clk);
        tests_run++; if (lat != SS + 1) begin tests_failed++; $display("FAIL byte_latency got %0d expected %0d", lat, SS + 1); end
        tests_run++; if (byte_data !== 8'hA5) begin tests_failed++; $display("FAIL byte_data got %h expected a5", byte_data); end
        tests_run++; if (byte_is_data !== 1'b1) begin tests_failed++; $display("FAIL byte_is_data got %b expected 1", byte_is_data); end
        tests_run++; if (byte_q.size() != 1) begin tests_failed++; $display("FAIL byte_count got %0d expected 1", byte_q.size()); end
        tests_run++; if (byte_valid !== 1'b0) begin tests_failed++; $display("FAIL byte_valid_pulse got %b expected 0", byte_valid); end
        $display("[TB] test_byte_assembly latency=%0d data=%h", lat, byte_data);
    endtask

    task automatic test_window_pixels();
        pix_t e [2];
        e[0] = '{9'd10, 8'd5, 16'hF800, 1'b0};
        e[1] = '{9'd11, 8'd5, 16'h07E0, 1'b1};
        pix_q.delete();
        send_cmd(8'h2A); send_data(8'd0); send_data(8'd10); send_data(8'd0); send_data(8'd11);
        send_cmd(8'h2B); send_data(8'd0); send_data(8'd5); send_data(8'd0); send_data(8'd5);
        send_cmd(8'h2C); send_word(16'hF800); send_word(16'h07E0);
        tests_run++; if (pix_q.size() != 2) begin tests_failed++; $display("FAIL window_pixel_count got %0d expected 2", pix_q.size()); end
        for (int i = 0; i < 2 && i < pix_q.size(); i++) begin
            tests_run++;
            if (pix_q[i] !== e[i]) begin
                tests_failed++;
                $display("FAIL window_pixel%0d got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", i,
                         pix_q[i].x, pix_q[i].y, pix_q[i].rgb, pix_q[i].fd, e[i].x, e[i].y, e[i].rgb, e[i].fd);
            end
        end
        $display("[TB] test_window_pixels pixels=%0d", pix_q.size());
    endtask

    task automatic test_cursor_wrap();
        pix_t e [5];
        e[0] = '{9'd318, 8'd238, 16'h0001, 1'b0};
        e[1] = '{9'd319, 8'd238, 16'h0002, 1'b0};
        e[2] = '{9'd318, 8'd239, 16'h0003, 1'b0};
        e[3] = '{9'd319, 8'd239, 16'h0004, 1'b1};
        e[4] = '{9'd318, 8'd238, 16'h0005, 1'b0};
        pix_q.delete();
        send_cmd(8'h2A); send_data(8'h01); send_data(8'h3E); send_data(8'h01); send_data(8'h3F);
        send_cmd(8'h2B); send_data(8'h00); send_data(8'hEE); send_data(8'h00); send_data(8'hEF);
        send_cmd(8'h2C);
        for (int i = 1; i <= 5; i++) send_word(16'(i));
        tests_run++; if (pix_q.size() != 5) begin tests_failed++; $display("FAIL wrap_pixel_count got %0d expected 5", pix_q.size()); end
        for (int i = 0; i < 5 && i < pix_q.size(); i++) begin
            tests_run++;
            if (pix_q[i] !== e[i]) begin
                tests_failed++;
                $display("FAIL wrap_pixel%0d got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", i,
                         pix_q[i].x, pix_q[i].y, pix_q[i].rgb, pix_q[i].fd, e[i].x, e[i].y, e[i].rgb, e[i].fd);
            end
        end
        $display("[TB] test_cursor_wrap pixels=%0d", pix_q.size());
    endtask

    task automatic test_partial_byte();
        pix_t e;
        e = '{9'd318, 8'd238, 16'hABCD, 1'b0};
        byte_q.delete();
        pix_q.delete();
        tft_cs = 1'b0;
        tft_dc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tft_sck = 1'b0; tft_sdi = 1'b1;
            repeat (3) @(negedge clk);
            tft_sck = 1'b1;
            repeat (3) @(negedge clk);
        end
        tft_sck = 1'b0;
        repeat (3) @(negedge clk);
        tft_cs = 1'b1;
        repeat (8) @(negedge clk);
        send_cmd(8'h2C);
        send_word(16'hABCD);
        tests_run++; if (byte_q.size() != 3) begin tests_failed++; $display("FAIL partial_byte_count got %0d expected 3", byte_q.size()); end
        if (byte_q.size() > 0) begin
            tests_run++; if (byte_q[0] !== 8'h2C) begin tests_failed++; $display("FAIL partial_first_byte got %h expected 2c", byte_q[0]); end
        end
        tests_run++; if (pix_q.size() != 1) begin tests_failed++; $display("FAIL partial_pixel_count got %0d expected 1", pix_q.size()); end
        if (pix_q.size() > 0) begin
            tests_run++;
            if (pix_q[0] !== e) begin
                tests_failed++;
                $display("FAIL partial_pixel got (%0d,%0d,%h,fd=%b) expected (318,238,abcd,fd=0)",
                         pix_q[0].x, pix_q[0].y, pix_q[0].rgb, pix_q[0].fd);
            end
        end
        $display("[TB] test_partial_byte bytes=%0d pixels=%0d", byte_q.size(), pix_q.size());
    endtask

    task automatic test_abort();
        pix_t e;
        e = '{9'd1, 8'd238, 16'h5566, 1'b0};
        pix_q.delete();
        send_cmd(8'h2C);
        send_data(8'h12);
        send_cmd(8'h2A); send_data(8'd0); send_data(8'd1); send_data(8'd0); send_data(8'd2);
        tests_run++; if (pix_q.size() != 0) begin tests_failed++; $display("FAIL abort_no_pixel got %0d expected 0", pix_q.size()); end
        send_cmd(8'h2C);
        send_word(16'h5566);
        tests_run++; if (pix_q.size() != 1) begin tests_failed++; $display("FAIL abort_pixel_count got %0d expected 1", pix_q.size()); end
        if (pix_q.size() > 0) begin
            tests_run++;
            if (pix_q[pix_q.size()-1] !== e) begin
                tests_failed++;
                $display("FAIL abort_window got (%0d,%0d,%h) expected (1,238,5566)",
                         pix_q[pix_q.size()-1].x, pix_q[pix_q.size()-1].y, pix_q[pix_q.size()-1].rgb);
            end
        end
        $display("[TB] test_abort pixels=%0d", pix_q.size());
    endtask

    task automatic test_tft_reset();
        pix_t e [2];
        e[0] = '{9'd0, 8'd0, 16'h7777, 1'b0};
        e[1] = '{9'd1, 8'd0, 16'h8888, 1'b0};
        pix_q.delete();
        send_cmd(8'h2C);
        send_data(8'h11);
        tft_reset = 1'b0;
        repeat (6) @(negedge clk);
        tft_reset = 1'b1;
        repeat (6) @(negedge clk);
        send_data(8'h33);
        send_data(8'h44);
        tests_run++; if (pix_q.size() != 0) begin tests_failed++; $display("FAIL treset_fsm_idle got %0d pixels expected 0", pix_q.size()); end
        send_cmd(8'h2C);
        send_word(16'h7777);
        send_word(16'h8888);
        tests_run++; if (pix_q.size() != 2) begin tests_failed++; $display("FAIL treset_pixel_count got %0d expected 2", pix_q.size()); end
        for (int i = 0; i < 2 && i < pix_q.size(); i++) begin
            tests_run++;
            if (pix_q[i] !== e[i]) begin
                tests_failed++;
                $display("FAIL treset_pixel%0d got (%0d,%0d,%h,fd=%b) expected (%0d,%0d,%h,fd=%b)", i,
                         pix_q[i].x, pix_q[i].y, pix_q[i].rgb, pix_q[i].fd, e[i].x, e[i].y, e[i].rgb, e[i].fd);
            end
        end
        $display("[TB] test_tft_reset pixels=%0d", pix_q.size());
    endtask

    initial begin
        test_reset();
        test_byte_assembly();
        test_window_pixels();
        test_cursor_wrap();
        test_partial_byte();
        test_abort();
        test_tft_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tft_spi_receiver.md
# tft_spi_receiver

Receive-side decoder for the 4-wire TFT SPI link (`tft_sck`, `tft_sdi`, `tft_dc`, `tft_cs`, `tft_reset`) that the game's image generator drives. It oversamples the link in the system clock domain, assembles bytes and tracks the ILI9341-style CASET/PASET/RAMWR command set. It emits one decoded pixel per completed RGB565 word, tagged with its screen coordinate. It serves as the on-chip loopback checker and frame-capture front end for the display path.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on all five link inputs; minimum 2.
- `X_MAX`, default 319: default column window end after reset or `tft_reset`.
- `Y_MAX`, default 239: default page window end after reset or `tft_reset`.
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `tft_sck`, `tft_sdi`, `tft_dc`, `tft_cs`, `tft_reset` in 1 each: link inputs, asynchronous to `clk`.
- `byte_valid` out 1: one-cycle pulse when a byte completes.
- `byte_data` out 8: last completed byte, held until the next byte completes.
- `byte_is_data` out 1: `tft_dc` value sampled with the byte's 8th bit (1 = data, 0 = command).
- `pixel_valid` out 1: one-cycle pulse for each decoded pixel.
- `pixel_x` out 9 and `pixel_y` out 8: coordinate of the current pixel.
- `pixel_rgb` out 16: RGB565 value, first byte in bits [15:8].
- `frame_done` out 1: one-cycle pulse when the pixel at (xe, ye) is written.

## Operation
- Synchronization and edge detection: every input passes through `SYNC_STAGES` flops. A sck rising edge is detected when the last synchronized stage is 1 and a one-flop delayed copy of it is 0.
- Bit capture: on each detected edge with synchronized cs = 0, shift sdi in MSB-first and increment a 3-bit counter. When the 8th bit arrives, pulse `byte_valid` and latch `byte_data` and `byte_is_data`.
- cs handling:
  - Synchronized cs = 1 clears the bit counter and discards any partial byte.
  - An sck edge sampled in the same cycle as cs = 1 is ignored.
- Decoder FSM states, all advancing on `byte_valid`:
  - IDLE: wait for a command byte.
  - Any command byte is accepted from any state, aborts the current sequence and selects the next state:
    - 0x2A (CASET) → CASET with a param index of 0.
    - 0x2B (PASET) → PASET with a param index of 0.
    - 0x2C (RAMWR) → RAMWR_HI, with the cursor loaded to (xs, ys).
    - Any other command → IDLE.
  - CASET: four data bytes load xs[15:8], xs[7:0], xe[15:8], xe[7:0], in that order. After the 4th byte → IDLE. Any further data bytes are ignored.
  - PASET: same as CASET, loading ys and ye.
  - RAMWR_HI: a data byte is latched as the high byte → RAMWR_LO.
  - RAMWR_LO: a data byte completes the pixel. Pulse `pixel_valid` with the cursor coordinate → RAMWR_HI, then advance the cursor.
  - Data bytes in IDLE are ignored.
- Width rules:
  - Window registers are 16 bits wide. The cursor uses xs[8:0]/xe[8:0] and ys[7:0]/ye[7:0].
  - If xs > xe, the window is a single column at xs. The same rule applies to ys > ye.
- Cursor advance:
  - If x ≠ xe: x + 1.
  - Otherwise x ← xs, and y advances the same way: if y ≠ ye, y + 1, otherwise y ← ys.
  - When the pixel written is at (xe, ye), assert `frame_done` in the same cycle as its `pixel_valid`, and wrap the cursor to (xs, ys).
- `tft_reset` low (synchronized) acts as a synchronous clear:
  - FSM → IDLE, bit counter cleared.
  - Window set to xs = 0, xe = `X_MAX`, ys = 0, ye = `Y_MAX`.
  - Output pulses suppressed.
- Reset values: all outputs 0. Window is (0, `X_MAX`, 0, `Y_MAX`), FSM is IDLE and the cursor is (0, 0).

## Timing
- Link constraint: sck high and low each last at least 2 `clk` periods. Setup/hold of sdi and dc relative to sck is met by the transmitter.
- `byte_valid` asserts exactly `SYNC_STAGES`+1 `clk` edges after the edge that first samples the 8th sck high.
- `pixel_valid` and `frame_done` assert one cycle after the `byte_valid` of the low byte. `pixel_x` and `pixel_y` are valid while `pixel_valid` is high.
- The cursor update takes effect the cycle after `pixel_valid`.
- No back-pressure: the receiver accepts every byte. The maximum byte rate is one per 32 `clk` cycles.
- Asynchronous `rst` assertion mid-byte clears everything immediately. The first byte after release must start on a fresh cs-low frame.

## Structure
- Shared package `tft_spi_pkg`:
  - Command constants `CMD_CASET`=8'h2A, `CMD_PASET`=8'h2B, `CMD_RAMWR`=8'h2C.
  - `rx_state_t` enum: IDLE, CASET, PASET, RAMWR_HI, RAMWR_LO.
- Sub-module `spi_byte_shifter`: synchronizers, edge detect, bit counter and byte output. The parent holds the FSM, window registers and cursor.

## Test plan
- Byte assembly: cs low, send 0xA5 MSB-first → one `byte_valid`, `byte_data`=0xA5 and `byte_is_data`=dc, with latency `SYNC_STAGES`+1.
- Window set and pixel order: CASET 0,10,0,11; PASET 0,5,0,5; RAMWR then words 0xF800, 0x07E0 → pixels (10,5,0xF800) and (11,5,0x07E0); `frame_done` on the second pixel.
- Cursor wrap: window x 318..319, y 238..239; write 5 pixels → (318,238), (319,238), (318,239), (319,239) with `frame_done`, then (318,238).
- Partial byte: 5 bits then cs high, then a full byte 0x2C → no byte from the fragment; RAMWR is entered.
- Abort: RAMWR, send a high byte 0x12, then command 0x2A plus 4 params → no `pixel_valid`; the window updates.
- `tft_reset` pulse mid-RAMWR → FSM IDLE, window (0,319,0,239); the next RAMWR pixel lands at (0,0).
